// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared constants, state encoding and checksum helper for the UART
// command controller.
package uart_cmd_ctrl_pkg;

    localparam logic [7:0] HEADER      = 8'h55;
    localparam logic [7:0] CMD_WR      = 8'h01;
    localparam logic [7:0] CMD_RD      = 8'h02;
    localparam int         TIMEOUT_DIV = 1000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_CHK  = 3'd4
    } state_t;

    function automatic logic [7:0] calc_chk(input logic [7:0] cmd,
                                            input logic [7:0] addr,
                                            input logic [7:0] data);
        return cmd ^ addr ^ data;
    endfunction

endpackage

// File: rtl/uart_byte_timer.sv
// Clearable inter-byte timeout counter; expired is high while the count
// sits at CYCLES-1 (the count holds there until cleared).
module uart_byte_timer #(
    parameter int CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic expired
);

    localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [CW-1:0] count_r;

    // Count idle cycles, clearing on request and holding at the terminal value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (count_r != LAST) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == LAST);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frame parser: 0x55 CMD ADDR DATA CHK -> register write/read strobes,
// with checksum/command validation and an inter-byte timeout.
module uart_cmd_ctrl
    import uart_cmd_ctrl_pkg::*;
#(
    parameter int CLOCK_FREQ = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic       wr_en,
    output logic       rd_en,
    output logic [7:0] addr,
    output logic [7:0] wdata,
    output logic       frame_err,
    output logic [7:0] err_count,
    output logic       busy
);

    localparam int TIMEOUT_CYCLES = CLOCK_FREQ / TIMEOUT_DIV;

    state_t     state_r, state_nxt_s;
    logic [7:0] cmd_r, addr_cap_r, data_cap_r;
    logic       expired_s, timer_clr_s;
    logic       do_wr_s, do_rd_s, do_err_s;

    assign timer_clr_s = rx_valid || (state_r == ST_IDLE);

    uart_byte_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (timer_clr_s),
        .expired (expired_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and frame verdict; an accepted byte takes priority over timeout
    always_comb begin
        state_nxt_s = state_r;
        do_wr_s     = 1'b0;
        do_rd_s     = 1'b0;
        do_err_s    = 1'b0;
        if (rx_valid) begin
            case (state_r)
                ST_IDLE: begin
                    if (rx_byte == HEADER) begin
                        state_nxt_s = ST_CMD;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_CMD:  state_nxt_s = ST_ADDR;
                ST_ADDR: state_nxt_s = ST_DATA;
                ST_DATA: state_nxt_s = ST_CHK;
                ST_CHK: begin
                    state_nxt_s = ST_IDLE;
                    if (rx_byte != calc_chk(cmd_r, addr_cap_r, data_cap_r)) begin
                        do_err_s = 1'b1;
                    end else if (cmd_r == CMD_WR) begin
                        do_wr_s = 1'b1;
                    end else if (cmd_r == CMD_RD) begin
                        do_rd_s = 1'b1;
                    end else begin
                        do_err_s = 1'b1;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end else if (expired_s && (state_r != ST_IDLE)) begin
            state_nxt_s = ST_IDLE;
            do_err_s    = 1'b1;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Capture CMD/ADDR/DATA bytes as they arrive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_r      <= 8'h00;
            addr_cap_r <= 8'h00;
            data_cap_r <= 8'h00;
        end else if (rx_valid) begin
            case (state_r)
                ST_CMD:  cmd_r      <= rx_byte;
                ST_ADDR: addr_cap_r <= rx_byte;
                ST_DATA: data_cap_r <= rx_byte;
                default: cmd_r      <= cmd_r;
            endcase
        end else begin
            cmd_r <= cmd_r;
        end
    end

    // Registered strobes, held address/data and saturating error count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            frame_err <= 1'b0;
            addr      <= 8'h00;
            wdata     <= 8'h00;
            err_count <= 8'h00;
        end else begin
            wr_en     <= do_wr_s;
            rd_en     <= do_rd_s;
            frame_err <= do_err_s;
            if (do_wr_s) begin
                addr  <= addr_cap_r;
                wdata <= data_cap_r;
            end else if (do_rd_s) begin
                addr  <= addr_cap_r;
            end else begin
                addr  <= addr;
            end
            if (do_err_s && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end else begin
                err_count <= err_count;
            end
        end
    end

    assign busy = (state_r != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed self-checking bench for uart_cmd_ctrl with a 10-cycle timeout.
module tb_uart_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       wr_en, rd_en, frame_err, busy;
    logic [7:0] addr, wdata, err_count;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int err_cnt = 0;

    uart_cmd_ctrl #(.CLOCK_FREQ(10000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .addr      (addr),
        .wdata     (wdata),
        .frame_err (frame_err),
        .err_count (err_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Count strobe cycles so single-pulse behaviour can be checked
    always @(negedge clk) begin
        if (wr_en)     wr_cnt  <= wr_cnt + 1;
        if (rd_en)     rd_cnt  <= rd_cnt + 1;
        if (frame_err) err_cnt <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] a,
                              input logic [7:0] d, input logic [7:0] k);
        send_byte(8'h55);
        send_byte(c);
        send_byte(a);
        send_byte(d);
        send_byte(k);
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        tick(2);
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_rd_en", {31'd0, rd_en}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_addr", {24'd0, addr}, 32'h00);
        check("rst_wdata", {24'd0, wdata}, 32'h00);
        check("rst_err_count", {24'd0, err_count}, 32'h00);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Write frame
        send_byte(8'h55); send_byte(8'h01); send_byte(8'h12); send_byte(8'hA5);
        check("wr_busy_mid", {31'd0, busy}, 32'd1);
        send_byte(8'hB6);
        check("wr_en", {31'd0, wr_en}, 32'd1);
        check("wr_addr", {24'd0, addr}, 32'h12);
        check("wr_wdata", {24'd0, wdata}, 32'hA5);
        check("wr_no_rd", {31'd0, rd_en}, 32'd0);
        check("wr_busy_done", {31'd0, busy}, 32'd0);
        tick(1);
        check("wr_pulse_end", {31'd0, wr_en}, 32'd0);
        check("wr_single", wr_cnt, 32'd1);
        check("wr_err_count", {24'd0, err_count}, 32'h00);

        // Read frame, followed back-to-back by a write frame
        send_frame(8'h02, 8'h34, 8'h00, 8'h36);
        check("rd_en", {31'd0, rd_en}, 32'd1);
        check("rd_addr", {24'd0, addr}, 32'h34);
        check("rd_wdata_held", {24'd0, wdata}, 32'hA5);
        check("rd_no_wr", {31'd0, wr_en}, 32'd0);
        send_frame(8'h01, 8'h40, 8'h3C, 8'h7D);
        check("b2b_wr_en", {31'd0, wr_en}, 32'd1);
        check("b2b_addr", {24'd0, addr}, 32'h40);
        check("b2b_wdata", {24'd0, wdata}, 32'h3C);
        tick(1);
        check("rd_single", rd_cnt, 32'd1);
        check("wr_count_2", wr_cnt, 32'd2);

        // Bad checksum, then invalid command
        send_frame(8'h01, 8'h12, 8'hA5, 8'h00);
        check("badchk_err", {31'd0, frame_err}, 32'd1);
        check("badchk_count", {24'd0, err_count}, 32'h01);
        check("badchk_addr_held", {24'd0, addr}, 32'h40);
        send_frame(8'h07, 8'h00, 8'h00, 8'h07);
        check("badcmd_err", {31'd0, frame_err}, 32'd1);
        check("badcmd_count", {24'd0, err_count}, 32'h02);
        tick(1);
        check("bad_no_wr", wr_cnt, 32'd2);
        check("bad_no_rd", rd_cnt, 32'd1);
        check("bad_wdata_held", {24'd0, wdata}, 32'h3C);

        // Timeout after 55 01 and ten idle cycles
        send_byte(8'h55); send_byte(8'h01);
        tick(9);
        check("to_busy_before", {31'd0, busy}, 32'd1);
        check("to_no_err_yet", {31'd0, frame_err}, 32'd0);
        tick(1);
        check("to_err", {31'd0, frame_err}, 32'd1);
        check("to_busy_after", {31'd0, busy}, 32'd0);
        check("to_count", {24'd0, err_count}, 32'h03);
        send_frame(8'h01, 8'h56, 8'h78, 8'h2F);
        check("to_next_wr", {31'd0, wr_en}, 32'd1);
        check("to_next_addr", {24'd0, addr}, 32'h56);

        // Byte arriving on the exact timeout cycle is accepted
        send_byte(8'h55); send_byte(8'h01);
        tick(9);
        send_byte(8'h66);
        check("edge_no_err", {31'd0, frame_err}, 32'd0);
        check("edge_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h11); send_byte(8'h76);
        check("edge_wr", {31'd0, wr_en}, 32'd1);
        check("edge_addr", {24'd0, addr}, 32'h66);
        check("edge_wdata", {24'd0, wdata}, 32'h11);
        check("edge_count", {24'd0, err_count}, 32'h03);

        // Noise before header, 0x55 taken as CMD data
        send_byte(8'h00); send_byte(8'hFF);
        check("noise_idle", {31'd0, busy}, 32'd0);
        check("noise_no_err", {31'd0, frame_err}, 32'd0);
        send_byte(8'h55); send_byte(8'h55); send_byte(8'h01); send_byte(8'h02);
        check("noise_chk_state", {31'd0, busy}, 32'd1);
        send_byte(8'h57);
        check("noise_err", {31'd0, frame_err}, 32'd1);
        check("noise_count", {24'd0, err_count}, 32'h04);
        tick(1);
        check("noise_err_single", err_cnt, 32'd4);

        // Saturation
        for (int i = 0; i < 300; i++) send_frame(8'h07, 8'h00, 8'h00, 8'h07);
        tick(1);
        check("sat_count", {24'd0, err_count}, 32'hFF);
        check("sat_wr_none", wr_cnt, 32'd4);

        // Reset mid-frame
        send_byte(8'h55); send_byte(8'h01); send_byte(8'h12);
        rst_n = 1'b0;
        #1;
        check("mrst_addr", {24'd0, addr}, 32'h00);
        check("mrst_wdata", {24'd0, wdata}, 32'h00);
        check("mrst_err_count", {24'd0, err_count}, 32'h00);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        tick(2);
        rst_n = 1'b1;
        send_byte(8'hA5); send_byte(8'hB6);
        tick(12);
        check("mrst_no_wr", wr_cnt, 32'd4);
        check("mrst_no_err", {24'd0, err_count}, 32'h00);
        check("mrst_idle", {31'd0, busy}, 32'd0);
        send_frame(8'h01, 8'h12, 8'hA5, 8'hB6);
        check("mrst_fresh_wr", {31'd0, wr_en}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
